// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the multiply/divide unit: MDOp codes and helpers.
package mdu_unit_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  // True for the four opcodes that start a multi-cycle operation.
  function automatic logic is_launch_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the two divide opcodes.
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_unit_calc.sv
// Combinational arithmetic core: produces the HI/LO pair for mult/multu/div/divu
// and flags a zero divisor so the top can suppress the write-back.
module mdu_unit_calc
  import mdu_unit_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  md_op_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_by_zero_o
);

  logic [63:0] prodS;
  logic [63:0] prodU;
  logic [31:0] divisor;
  logic [31:0] absA;
  logic [31:0] absB;
  logic [31:0] quotS;
  logic [31:0] remS;
  logic [31:0] quotU;
  logic [31:0] remU;

  // Signed divide works on magnitudes and fixes signs afterwards, which also
  // yields 0x80000000 / 0 for the -2^31 / -1 overflow case without a special path.
  // A zero divisor is replaced by 1 so no X is generated; the result is discarded.
  always_comb begin
    prodS   = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    prodU   = {32'b0, a_i} * {32'b0, b_i};
    divisor = (b_i == 32'd0) ? 32'd1 : b_i;
    absA    = a_i[31] ? (32'd0 - a_i) : a_i;
    absB    = divisor[31] ? (32'd0 - divisor) : divisor;
    quotU   = a_i / divisor;
    remU    = a_i % divisor;
    quotS   = absA / absB;
    remS    = absA % absB;
    if (a_i[31] != divisor[31]) quotS = 32'd0 - quotS;
    if (a_i[31]) remS = 32'd0 - remS;

    hi_o = 32'd0;
    lo_o = 32'd0;
    case (md_op_i)
      MD_MULT:  begin hi_o = prodS[63:32]; lo_o = prodS[31:0]; end
      MD_MULTU: begin hi_o = prodU[63:32]; lo_o = prodU[31:0]; end
      MD_DIV:   begin hi_o = remS;         lo_o = quotS;       end
      MD_DIVU:  begin hi_o = remU;         lo_o = quotU;       end
      default:  begin hi_o = 32'd0;        lo_o = 32'd0;       end
    endcase
    div_by_zero_o = is_div_op(md_op_i) && (b_i == 32'd0);
  end

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit for the E stage. The result is computed at launch and
// held in tmp registers; a down-counter models the fixed latency, and HI/LO
// are committed on the edge where the counter reaches zero.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   tmp_hi_q, tmp_hi_d;
  logic [31:0]   tmp_lo_q, tmp_lo_d;
  logic          dbz_q, dbz_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic [31:0]   calcHi;
  logic [31:0]   calcLo;
  logic          calcDbz;
  logic          launch;
  logic          done;
  logic          idleMove;

  mdu_unit_calc u_calc (
    .a_i           (A),
    .b_i           (B),
    .md_op_i       (MDOp),
    .hi_o          (calcHi),
    .lo_o          (calcLo),
    .div_by_zero_o (calcDbz)
  );

  assign Busy = (cnt_q != '0);
  assign HI   = hi_q;
  assign LO   = lo_q;

  // Next-state logic: launch is accepted when idle or on the completing edge,
  // so a back-to-back operation can start while the previous one commits.
  always_comb begin
    done     = (cnt_q == CW'(1));
    launch   = Start && ((cnt_q == '0) || done) && is_launch_op(MDOp);
    idleMove = !Busy && !Start;

    cnt_d    = cnt_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    if (launch) begin
      cnt_d    = is_div_op(MDOp) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      tmp_hi_d = calcHi;
      tmp_lo_d = calcLo;
      dbz_d    = calcDbz;
    end

    if (done && !dbz_q) begin
      hi_d = tmp_hi_q;
      lo_d = tmp_lo_q;
    end
    if (idleMove && (MDOp == MD_MTHI)) hi_d = A;
    if (idleMove && (MDOp == MD_MTLO)) lo_d = A;
  end

  // State registers; reset clears everything and drops any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
      dbz_q    <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      cnt_q    <= cnt_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Move-from read port reflects only the committed HI/LO.
  always_comb begin
    case (MDOp)
      MD_MFHI: MDOut = hi_q;
      MD_MFLO: MDOut = lo_q;
      default: MDOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDOut;

  int total;
  int bad;
  int busyCnt;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .MDOp  (MDOp),
    .Start (Start),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO),
    .MDOut (MDOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse Start for one cycle with a launch op, then count Busy cycles (bounded).
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    A = a; B = b; MDOp = op; Start = 1'b1;
    tick();
    Start = 1'b0; MDOp = MD_NONE; A = 32'd0; B = 32'd0;
    busyCnt = 0;
    while (Busy && busyCnt < 50) begin
      busyCnt++;
      tick();
    end
  endtask

  task automatic moveTo(input logic [3:0] op, input logic [31:0] a);
    A = a; MDOp = op; Start = 1'b0;
    tick();
    MDOp = MD_NONE; A = 32'd0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; A = 32'd0; B = 32'd0; MDOp = MD_NONE; Start = 1'b0;
    #12;
    checkOutput("rst_busy", {31'd0, Busy}, 32'd0);
    checkOutput("rst_hi", HI, 32'd0);
    checkOutput("rst_lo", LO, 32'd0);
    rst_n = 1'b1;
    tick();

    // MULT -2 * 3
    applyStimulus(MD_MULT, 32'hFFFFFFFE, 32'd3);
    checkOutput("mult_busy", busyCnt, 32'd5);
    checkOutput("mult_hi", HI, 32'hFFFFFFFF);
    checkOutput("mult_lo", LO, 32'hFFFFFFFA);
    MDOp = MD_MFLO; #1;
    checkOutput("mflo", MDOut, 32'hFFFFFFFA);
    MDOp = MD_MFHI; #1;
    checkOutput("mfhi", MDOut, 32'hFFFFFFFF);
    MDOp = 4'd9; #1;
    checkOutput("mdout_other", MDOut, 32'd0);
    MDOp = MD_NONE;

    // MULTU max * max
    applyStimulus(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checkOutput("multu_busy", busyCnt, 32'd5);
    checkOutput("multu_hi", HI, 32'hFFFFFFFE);
    checkOutput("multu_lo", LO, 32'h00000001);

    // DIV -7 / 2
    applyStimulus(MD_DIV, 32'hFFFFFFF9, 32'd2);
    checkOutput("div_busy", busyCnt, 32'd10);
    checkOutput("div_lo", LO, 32'hFFFFFFFD);
    checkOutput("div_hi", HI, 32'hFFFFFFFF);

    // Signed overflow -2^31 / -1
    applyStimulus(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    checkOutput("ovf_lo", LO, 32'h80000000);
    checkOutput("ovf_hi", HI, 32'd0);

    // MTHI/MTLO then DIVU by zero leaves HI/LO unchanged
    moveTo(MD_MTHI, 32'h1234);
    moveTo(MD_MTLO, 32'h5678);
    checkOutput("mthi", HI, 32'h1234);
    checkOutput("mtlo", LO, 32'h5678);
    applyStimulus(MD_DIVU, 32'd7, 32'd0);
    checkOutput("dbz_busy", busyCnt, 32'd10);
    checkOutput("dbz_hi", HI, 32'h1234);
    checkOutput("dbz_lo", LO, 32'h5678);

    // DIV 100 / 7 with an ignored MULT launch and ignored MTLO while busy
    A = 32'd100; B = 32'd7; MDOp = MD_DIV; Start = 1'b1;
    tick();
    Start = 1'b0; MDOp = MD_NONE; A = 32'd0; B = 32'd0;
    busyCnt = 0;
    while (Busy && busyCnt < 50) begin
      if (busyCnt == 2) begin
        A = 32'd3; B = 32'd3; MDOp = MD_MULT; Start = 1'b1;
      end else if (busyCnt == 4) begin
        A = 32'hAAAA; B = 32'd0; MDOp = MD_MTLO; Start = 1'b0;
      end else begin
        A = 32'd0; B = 32'd0; MDOp = MD_NONE; Start = 1'b0;
      end
      busyCnt++;
      tick();
    end
    A = 32'd0; B = 32'd0; MDOp = MD_NONE; Start = 1'b0;
    checkOutput("ign_busy", busyCnt, 32'd10);
    checkOutput("ign_lo", LO, 32'd14);
    checkOutput("ign_hi", HI, 32'd2);

    // Async reset in the middle of MULT 6 x 7
    A = 32'd6; B = 32'd7; MDOp = MD_MULT; Start = 1'b1;
    tick();
    Start = 1'b0; MDOp = MD_NONE;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", {31'd0, Busy}, 32'd0);
    checkOutput("arst_hi", HI, 32'd0);
    checkOutput("arst_lo", LO, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checkOutput("post_rst_busy", {31'd0, Busy}, 32'd0);
    checkOutput("post_rst_lo", LO, 32'd0);
    checkOutput("post_rst_hi", HI, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
